window_sum: RTL and testbench
=============================

WINDOW_SUM -- requirements
Module: window_sum

Interface
REQ-001 Parameter BITWIDTH, default 32, SHALL set the width of each input sample.
REQ-002 Parameter DEPTH, default 8, SHALL set the window length in accepted samples (legal range 2..256).
REQ-003 Port iClk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port iRstN  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port iEn  input  1  SHALL qualify iData; a sample is accepted on each rising edge with iEn=1 and iClr=0.
REQ-006 Port iClr  input  1  SHALL be a synchronous clear of the window contents.
REQ-007 Port iData  input  BITWIDTH  SHALL be the unsigned sample.
REQ-008 Port oSum  output  BITWIDTH+clog2(DEPTH)  SHALL be the unsigned sum of the last DEPTH accepted samples; before the window fills, samples not yet received count as 0.
REQ-009 Port oValid  output  1  SHALL be high when DEPTH samples have been accepted since the last reset or clear.
REQ-010 Port oFill  output  clog2(DEPTH)+1  SHALL be the number of accepted samples, saturating at DEPTH.

Function
REQ-011 Delay line: the block SHALL hold the last DEPTH accepted samples in a DEPTH-stage delay line that advances only on an accepted sample.
REQ-012 Update: on an accepted sample, oSum SHALL become oSum + iData - oldest, where oldest is the sample accepted DEPTH accepts earlier, or 0 if none exists.
REQ-013 Latency: oSum, oValid and oFill SHALL be registered and reflect an accepted sample one cycle after its edge.
REQ-014 Hold: with iEn=0 and iClr=0, all outputs and the delay line SHALL hold their values.
REQ-015 Width: the internal sum SHALL be BITWIDTH+clog2(DEPTH) bits; DEPTH*(2^BITWIDTH-1) SHALL never wrap, and the subtraction SHALL never underflow.
REQ-016 FSM: the block SHALL have two states, FILL and RUN; it SHALL enter FILL on reset or clear.
REQ-017 FILL->RUN: the block SHALL move from FILL to RUN on the accepted sample that brings oFill to DEPTH; oValid SHALL be 1 exactly when the state is RUN.
REQ-018 RUN: the block SHALL stay in RUN until clear or reset, with oFill held at DEPTH.
REQ-019 Clear: iClr=1 SHALL on the next edge zero oSum, oFill, oValid and every delay-line stage, and SHALL return the state to FILL.
REQ-020 Clear priority: iClr=1 together with iEn=1 SHALL act as a clear only; iData is discarded.
REQ-021 Clear then data: a sample accepted on the cycle after a clear SHALL be treated as the first sample of a new window.

Reset
REQ-022 Reset assertion: iRstN=0 SHALL immediately force oSum=0, oFill=0, oValid=0, all delay-line stages to 0, and state FILL, without waiting for a clock edge.
REQ-023 Mid-operation reset: reset asserted during either state SHALL discard all window contents; the first accepted sample after deassertion SHALL start a new window.

Structure
REQ-024 Delay line: the delay line SHALL be one instance of the existing shift_register sub-module (BITWIDTH, DEPTH), sharing iClk, iRstN and iClr, with its iEn driven by the accepted-sample strobe.
REQ-025 Oldest sample: the shift_register output SHALL be used directly as the oldest sample.
REQ-026 Local logic: the sum width, fill-counter width and FSM state encodings SHALL be local parameters derived from BITWIDTH and DEPTH; no shared package is needed, except a clog2 helper in the common header if one is absent.

Verification (BITWIDTH=8, DEPTH=4)
REQ-027 Fill: accept 1,2,3,4 on consecutive cycles -> oSum 1,3,6,10; oFill 1,2,3,4; oValid rises with oSum=10.
REQ-028 Slide with gaps: after REQ-027, accept 5, drop iEn for 3 cycles, then accept 6 -> oSum 14, held at 14 for 3 cycles, then 18; oValid stays 1.
REQ-029 Max: accept 255 eight times -> oSum saturates at 1020 from the 4th sample onward, with no wrap.
REQ-030 Clear: with oSum=18, drive iClr=1 with iEn=1 and iData=9 -> next cycle oSum=0, oValid=0, oFill=0; then accept 7 -> oSum=7, oFill=1.
REQ-031 Reset: pulse iRstN low mid-cycle during RUN -> outputs go to 0 before the next edge; then accept 2,2,2,2 -> oSum=8 and oValid=1 on the 4th sample.
REQ-032 Random: 10k cycles of random iEn, iClr and iData, checked each cycle against a reference model of the sum of the last 4 accepted samples.

Source files
------------

// File: rtl/window_sum_pkg.sv
// Shared helpers for the window_sum block.
package window_sum_pkg;

    // Ceiling log2 usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/window_sum_shift_register.sv
// DEPTH-stage delay line that advances on iEn; oData is the last stage.
module shift_register #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iEn,
    input  logic [BITWIDTH-1:0] iData,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH-1:0] stage_reg  [DEPTH];
    logic [BITWIDTH-1:0] stage_next [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = iData;
            end else begin : g_tail
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (iClr) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (iEn) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= stage_next[i];
        end
    end

    assign oData = stage_reg[DEPTH-1];

endmodule

// File: rtl/window_sum.sv
// Running sum of the last DEPTH accepted samples, with fill count and valid flag.
module window_sum
    import window_sum_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                                iClk,
    input  logic                                iRstN,
    input  logic                                iEn,
    input  logic                                iClr,
    input  logic [BITWIDTH-1:0]                 iData,
    output logic [BITWIDTH+clog2(DEPTH)-1:0]    oSum,
    output logic                                oValid,
    output logic [clog2(DEPTH):0]               oFill
);

    localparam int SUM_W  = BITWIDTH + clog2(DEPTH);
    localparam int FILL_W = clog2(DEPTH) + 1;

    localparam logic STATE_FILL = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    logic                accept;
    logic [BITWIDTH-1:0] oldest;
    logic [SUM_W-1:0]    sum_reg;
    logic [SUM_W-1:0]    sum_next;
    logic [FILL_W-1:0]   fill_reg;
    logic                state_reg;

    assign accept = iEn & ~iClr;

    shift_register #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH)
    ) u_delay (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iClr  (iClr),
        .iEn   (accept),
        .iData (iData),
        .oData (oldest)
    );

    // oldest is always part of sum_reg, so the subtraction cannot underflow.
    assign sum_next = sum_reg + SUM_W'(iData) - SUM_W'(oldest);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            sum_reg   <= '0;
            fill_reg  <= '0;
            state_reg <= STATE_FILL;
        end else if (iClr) begin
            sum_reg   <= '0;
            fill_reg  <= '0;
            state_reg <= STATE_FILL;
        end else if (accept) begin
            sum_reg <= sum_next;
            if (state_reg == STATE_FILL) begin
                fill_reg <= fill_reg + FILL_W'(1);
                if (fill_reg == FILL_W'(DEPTH - 1)) begin
                    state_reg <= STATE_RUN;
                end
            end
        end
    end

    assign oSum   = sum_reg;
    assign oFill  = fill_reg;
    assign oValid = (state_reg == STATE_RUN);

endmodule

// File: tb/tb_window_sum.sv
// Directed and randomized checks of window_sum against a queue-based model.
module tb_window_sum;

    localparam int BW = 8;
    localparam int D  = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic [BW-1:0] data;
    logic [9:0]    sum;
    logic          valid;
    logic [2:0]    fill;

    int errors = 0;
    int checks = 0;
    int hist[$];

    window_sum #(.BITWIDTH(BW), .DEPTH(D)) dut (
        .iClk   (clk),
        .iRstN  (rst_n),
        .iEn    (en),
        .iClr   (clr),
        .iData  (data),
        .oSum   (sum),
        .oValid (valid),
        .oFill  (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".sum"},   int'(sum),   model_sum());
        check({tag, ".fill"},  int'(fill),  hist.size());
        check({tag, ".valid"}, int'(valid), (hist.size() == D) ? 1 : 0);
    endtask

    // One clock: drive inputs, update the model at the edge, compare 1 time unit later.
    task automatic step(input logic e, input logic c, input int d, input string tag);
        en   = e;
        clr  = c;
        data = BW'(d);
        @(posedge clk);
        if (c) begin
            hist.delete();
        end else if (e) begin
            hist.push_back(d);
            if (hist.size() > D) void'(hist.pop_front());
        end
        #1;
        $display("%s en=%0d clr=%0d data=%0d -> sum=%0d fill=%0d valid=%0d",
                 tag, e, c, d, sum, fill, valid);
        check_model(tag);
    endtask

    initial begin
        int fill_seq [4] = '{1, 3, 6, 10};
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.sum",   int'(sum),   0);
        check("reset.fill",  int'(fill),  0);
        check("reset.valid", int'(valid), 0);
        rst_n = 1'b1;

        // Fill with 1..4
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, i + 1, "fill");
            check("fill.const_sum",  int'(sum),  fill_seq[i]);
            check("fill.const_fill", int'(fill), i + 1);
        end
        check("fill.const_valid", int'(valid), 1);

        // Slide with gaps
        step(1'b1, 1'b0, 5, "slide");
        check("slide.const14", int'(sum), 14);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 99, "hold");
            check("hold.const14", int'(sum), 14);
        end
        step(1'b1, 1'b0, 6, "slide");
        check("slide.const18", int'(sum), 18);
        check("slide.valid",   int'(valid), 1);

        // Clear with simultaneous enable discards data
        step(1'b1, 1'b1, 9, "clear");
        check("clear.const_sum",  int'(sum),  0);
        check("clear.const_fill", int'(fill), 0);
        step(1'b1, 1'b0, 7, "after_clr");
        check("after_clr.const_sum",  int'(sum),  7);
        check("after_clr.const_fill", int'(fill), 1);

        // Maximum samples must not wrap
        step(1'b1, 1'b1, 0, "clear");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 255, "max");
            if (i >= 3) check("max.const1020", int'(sum), 1020);
        end

        // Asynchronous reset between edges during RUN
        #2;
        rst_n = 1'b0;
        hist.delete();
        #1;
        check("async_rst.sum",   int'(sum),   0);
        check("async_rst.fill",  int'(fill),  0);
        check("async_rst.valid", int'(valid), 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2, "post_rst");
        check("post_rst.const_sum",   int'(sum),   8);
        check("post_rst.const_valid", int'(valid), 1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            logic e;
            logic c;
            int   d;
            e = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 39) == 0);
            d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
            step(e, c, d, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
